// File: rtl/digit_scanner_if.sv
// Load channel for the digit scanner: a full BCD value offered over valid/ready.
// The master drives value/load_valid; the scanner (slave) answers with load_ready.
interface digit_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load_valid;
  logic                load_ready;

  modport master (output value, load_valid, input load_ready);
  modport slave  (input value, load_valid, output load_ready);
endinterface

// File: rtl/digit_scanner.sv
// Time-multiplexed scan driver for a multi-digit seven-segment display with a
// double-buffered BCD value, frame-aligned commit and optional leading-zero blanking.
module digit_scanner #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  digit_scanner_if.slave     load,
  input  logic               blank_lz,
  output logic [3:0]         d,
  output logic [DIGITS-1:0]  an,
  output logic               frame
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [4*DIGITS-1:0]  active;
  logic [4*DIGITS-1:0]  pending;
  logic                 pend_full;
  logic                 tick;
  logic                 xfer;
  logic [DIGITS-1:0]    blanked;
  logic                 upper_zero;

  assign tick            = (cnt == CNT_MAX);
  assign frame           = tick && (idx == IDX_MAX);
  assign load.load_ready = ~pend_full;
  assign xfer            = load.load_valid && ~pend_full;

  // A transfer can only happen while pending is empty, so it never collides
  // with a commit; a transfer on a frame boundary therefore waits a full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (frame && pend_full) begin
        active    <= pending;
        pend_full <= 1'b0;
      end
      if (xfer) begin
        pending   <= load.value;
        pend_full <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a digit blanks while every
  // nibble from the top down to it is zero. Digit 0 always shows.
  always_comb begin
    blanked    = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (active[4*i +: 4] == 4'd0);
      blanked[i] = blank_lz && upper_zero;
    end
  end

  always_comb begin
    d  = '0;
    an = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i) && !blanked[i]) begin
        d     = active[4*i +: 4];
        an[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// Self-checking bench for digit_scanner (DIGITS=4, DIV=4): a cycle-count based
// reference model checked every cycle, a blanking vector table and directed sequences.
module tb_digit_scanner;

  localparam int DIGITS   = 4;
  localparam int DIV      = 4;
  localparam int FRAMELEN = DIGITS * DIV;

  logic        clk;
  logic        rst;
  logic        blank_lz;
  logic [3:0]  d;
  logic [3:0]  an;
  logic        frame;

  digit_scanner_if #(.DIGITS(DIGITS)) lif ();

  digit_scanner #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (lif.slave),
    .blank_lz (blank_lz),
    .d        (d),
    .an       (an),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: position in the scan is derived purely from the number
  // of cycles since reset; only the two buffers and the full flag are tracked.
  int          t = 0;
  logic [15:0] mActive  = '0;
  logic [15:0] mPending = '0;
  bit          mFull    = 1'b0;

  typedef struct {
    logic [15:0]      value;
    logic             blank;
    logic [3:0][3:0]  expD;
    logic [3:0][3:0]  expAn;
  } vec_t;

  vec_t vecs[7];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, t, act, exp);
    end
  endtask

  task automatic checkOutput();
    int          pos;
    logic [15:0] upper;
    logic [3:0]  eD;
    logic [3:0]  eAn;
    bit          eFrame;
    pos    = (t / DIV) % DIGITS;
    upper  = mActive >> (4 * pos);
    eFrame = (t % FRAMELEN) == FRAMELEN - 1;
    if (pos > 0 && blank_lz && upper == 16'd0) begin
      eD  = 4'd0;
      eAn = 4'd0;
    end else begin
      eD  = upper[3:0];
      eAn = 4'(1 << pos);
    end
    checkVal("model {d,an,frame,ready}",
             {22'd0, d, an, frame, lif.load_ready},
             {22'd0, eD, eAn, eFrame, ~mFull});
  endtask

  task automatic applyStimulus();
    bit isFrame;
    bit xfer;
    isFrame = (t % FRAMELEN) == FRAMELEN - 1;
    xfer    = lif.load_valid && !mFull;
    if (rst) begin
      t        = 0;
      mActive  = '0;
      mPending = '0;
      mFull    = 1'b0;
    end else begin
      if (isFrame && mFull) begin
        mActive = mPending;
        mFull   = 1'b0;
      end
      if (xfer) begin
        mPending = lif.value;
        mFull    = 1'b1;
      end
      t++;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runTo(input int target);
    while (t < target) applyStimulus();
  endtask

  task automatic doReset();
    rst            = 1'b1;
    lif.load_valid = 1'b0;
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    blank_lz       = 1'b0;
    lif.value      = '0;
    lif.load_valid = 1'b0;

    // expD/expAn are listed as {digit3, digit2, digit1, digit0}
    vecs[0] = '{16'h0042, 1'b1, {4'h0, 4'h0, 4'h4, 4'h2}, {4'h0, 4'h0, 4'h2, 4'h1}};
    vecs[1] = '{16'h0000, 1'b1, {4'h0, 4'h0, 4'h0, 4'h0}, {4'h0, 4'h0, 4'h0, 4'h1}};
    vecs[2] = '{16'h0402, 1'b1, {4'h0, 4'h4, 4'h0, 4'h2}, {4'h0, 4'h4, 4'h2, 4'h1}};
    vecs[3] = '{16'h1234, 1'b0, {4'h1, 4'h2, 4'h3, 4'h4}, {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[4] = '{16'h0042, 1'b0, {4'h0, 4'h0, 4'h4, 4'h2}, {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[5] = '{16'hABCF, 1'b1, {4'hA, 4'hB, 4'hC, 4'hF}, {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[6] = '{16'h0007, 1'b1, {4'h0, 4'h0, 4'h0, 4'h7}, {4'h0, 4'h0, 4'h0, 4'h1}};

    // Reset state and plain scan
    doReset();
    checkVal("reset ready", 32'(lif.load_ready), 32'd1);
    checkVal("reset d", 32'(d), 32'd0);
    checkVal("reset an", 32'(an), 32'd1);
    checkVal("reset frame", 32'(frame), 32'd0);
    runTo(4);  checkVal("scan an c4", 32'(an), 32'd2);
    runTo(12); checkVal("scan an c12", 32'(an), 32'd8);
    runTo(15); checkVal("frame c15", 32'(frame), 32'd1);
    runTo(16); checkVal("frame c16", 32'(frame), 32'd0);
    checkVal("scan an c16", 32'(an), 32'd1);
    runTo(31); checkVal("frame c31", 32'(frame), 32'd1);
    runTo(47); checkVal("frame c47", 32'(frame), 32'd1);

    // Load at cycle 5, commit at the first frame boundary
    doReset();
    runTo(5);
    lif.value = 16'h1234; lif.load_valid = 1'b1;
    applyStimulus();
    lif.load_valid = 1'b0;
    checkVal("load ready c6", 32'(lif.load_ready), 32'd0);
    runTo(15); checkVal("load d c15", 32'(d), 32'd0);
    runTo(16); checkVal("load ready c16", 32'(lif.load_ready), 32'd1);
    checkVal("load d c16", 32'(d), 32'd4);
    runTo(20); checkVal("load d c20", 32'(d), 32'd3);
    runTo(24); checkVal("load d c24", 32'(d), 32'd2);
    runTo(28); checkVal("load d c28", 32'(d), 32'd1);

    // Back-pressure: the second offer is ignored while pending is full
    doReset();
    runTo(2);
    lif.value = 16'h1111; lif.load_valid = 1'b1;
    applyStimulus();
    lif.value = 16'h9999;
    runTo(15);
    lif.load_valid = 1'b0;
    for (int c = 16; c < 48; c += 4) begin
      runTo(c);
      checkVal("backpressure d", 32'(d), 32'd1);
    end

    // Transfer exactly on a frame boundary waits a whole frame
    doReset();
    runTo(15);
    lif.value = 16'h5678; lif.load_valid = 1'b1;
    applyStimulus();
    lif.load_valid = 1'b0;
    checkVal("coincident ready c16", 32'(lif.load_ready), 32'd0);
    checkVal("coincident d c16", 32'(d), 32'd0);
    runTo(28); checkVal("coincident d c28", 32'(d), 32'd0);
    runTo(32); checkVal("coincident d c32", 32'(d), 32'd8);
    checkVal("coincident ready c32", 32'(lif.load_ready), 32'd1);
    runTo(36); checkVal("coincident d c36", 32'(d), 32'd7);

    // Reset while a value is pending discards it
    doReset();
    runTo(3);
    lif.value = 16'h4321; lif.load_valid = 1'b1;
    applyStimulus();
    lif.load_valid = 1'b0;
    runTo(8);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkVal("midreset ready", 32'(lif.load_ready), 32'd1);
    checkVal("midreset an", 32'(an), 32'd1);
    checkVal("midreset d", 32'(d), 32'd0);
    for (int c = 16; c < 40; c += 4) begin
      runTo(c);
      checkVal("midreset d later", 32'(d), 32'd0);
    end

    // Blanking vector table: load, let it commit, inspect each digit slot
    foreach (vecs[v]) begin
      doReset();
      blank_lz       = vecs[v].blank;
      lif.value      = vecs[v].value;
      lif.load_valid = 1'b1;
      applyStimulus();
      lif.load_valid = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
        runTo(16 + DIV * k + 1);
        checkVal($sformatf("vec%0d d slot%0d", v, k), 32'(d), 32'(vecs[v].expD[k]));
        checkVal($sformatf("vec%0d an slot%0d", v, k), 32'(an), 32'(vecs[v].expAn[k]));
      end
    end

    // Randomized traffic against the model, with occasional resets
    blank_lz = 1'b0;
    doReset();
    for (int n = 0; n < 1500; n++) begin
      lif.value      = 16'($urandom);
      lif.load_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
